// File: rtl/flash_arb.sv
// Two-client round-robin arbiter in front of the SPI flash controller's START/FINISH handshake.
// Latency: GNT+START one cycle after accept; DONE/ERR one cycle after FINISH or watchdog expiry.
// Backpressure: REQn_I is held until GNTn_O; no accept while FL_BUSY_I is high or a command is in flight.
//
// Ports:
//   SYS_CLK_I, SYS_RST_I                  clock, synchronous active-high reset
//   REQn_I / REQn_CMD_I / REQn_ADDR_I /   client n request level and command fields
//   REQn_BYTE_NUM_I / REQn_PDATA_I
//   GNTn_O / DONEn_O / ERRn_O             per-client single-cycle status pulses
//   RD_DATA_O                             read data of the last finished command
//   FL_CMD_O/ADDR_O/BYTE_NUM_O/PDATA_O    registered command fields to the controller
//   FL_START_O                            single-cycle START to the controller
//   FL_PDATA_I / FL_BUSY_I / FL_FINISH_I  controller read data, busy and completion
module flash_arb #(
  parameter int unsigned C_MAX_BYTE_NUM    = 1,
  parameter logic [31:0] C_TIMEOUT_CLK_NUM = 32'd50000000,
  localparam int BW = $clog2(C_MAX_BYTE_NUM) + 1,
  localparam int DW = C_MAX_BYTE_NUM * 8
) (
  input  logic          SYS_CLK_I,
  input  logic          SYS_RST_I,
  input  logic          REQ0_I,
  input  logic [7:0]    REQ0_CMD_I,
  input  logic [23:0]   REQ0_ADDR_I,
  input  logic [BW-1:0] REQ0_BYTE_NUM_I,
  input  logic [DW-1:0] REQ0_PDATA_I,
  input  logic          REQ1_I,
  input  logic [7:0]    REQ1_CMD_I,
  input  logic [23:0]   REQ1_ADDR_I,
  input  logic [BW-1:0] REQ1_BYTE_NUM_I,
  input  logic [DW-1:0] REQ1_PDATA_I,
  output logic          GNT0_O,
  output logic          GNT1_O,
  output logic          DONE0_O,
  output logic          DONE1_O,
  output logic          ERR0_O,
  output logic          ERR1_O,
  output logic [DW-1:0] RD_DATA_O,
  output logic [7:0]    FL_CMD_O,
  output logic [23:0]   FL_ADDR_O,
  output logic [BW-1:0] FL_BYTE_NUM_O,
  output logic [DW-1:0] FL_PDATA_O,
  output logic          FL_START_O,
  input  logic [DW-1:0] FL_PDATA_I,
  input  logic          FL_BUSY_I,
  input  logic          FL_FINISH_I
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic        pri;     // client that wins when both request
  logic        owner;   // client that owns the command in flight
  logic [31:0] wdog;
  logic        req_any;
  logic        win;

  assign req_any = REQ0_I | REQ1_I;
  // Single requester wins outright; a tie goes to the priority pointer.
  assign win     = (REQ0_I & REQ1_I) ? pri : REQ1_I;

  always_ff @(posedge SYS_CLK_I) begin
    if (SYS_RST_I) begin
      state         <= S_IDLE;
      pri           <= 1'b0;
      owner         <= 1'b0;
      wdog          <= '0;
      GNT0_O        <= 1'b0;
      GNT1_O        <= 1'b0;
      DONE0_O       <= 1'b0;
      DONE1_O       <= 1'b0;
      ERR0_O        <= 1'b0;
      ERR1_O        <= 1'b0;
      RD_DATA_O     <= '0;
      FL_CMD_O      <= '0;
      FL_ADDR_O     <= '0;
      FL_BYTE_NUM_O <= '0;
      FL_PDATA_O    <= '0;
      FL_START_O    <= 1'b0;
    end else begin
      // Status pulses and START are single-cycle by default.
      GNT0_O     <= 1'b0;
      GNT1_O     <= 1'b0;
      DONE0_O    <= 1'b0;
      DONE1_O    <= 1'b0;
      ERR0_O     <= 1'b0;
      ERR1_O     <= 1'b0;
      FL_START_O <= 1'b0;
      case (state)
        S_IDLE: begin
          // Busy also covers the controller's own power-up read and a
          // controller still stuck after a watchdog abort.
          if (!FL_BUSY_I && req_any) begin
            owner         <= win;
            wdog          <= '0;
            GNT0_O        <= ~win;
            GNT1_O        <= win;
            FL_START_O    <= 1'b1;
            FL_CMD_O      <= win ? REQ1_CMD_I      : REQ0_CMD_I;
            FL_ADDR_O     <= win ? REQ1_ADDR_I     : REQ0_ADDR_I;
            FL_BYTE_NUM_O <= win ? REQ1_BYTE_NUM_I : REQ0_BYTE_NUM_I;
            FL_PDATA_O    <= win ? REQ1_PDATA_I    : REQ0_PDATA_I;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          // FINISH takes precedence over a watchdog expiry in the same cycle.
          if (FL_FINISH_I) begin
            RD_DATA_O <= FL_PDATA_I;
            DONE0_O   <= ~owner;
            DONE1_O   <= owner;
            pri       <= ~owner;
            state     <= S_DONE;
          end else if (wdog == C_TIMEOUT_CLK_NUM - 32'd1) begin
            ERR0_O <= ~owner;
            ERR1_O <= owner;
            pri    <= ~owner;
            state  <= S_DONE;
          end else begin
            // Leaves the state before reaching the limit, so it never wraps.
            wdog <= wdog + 32'd1;
          end
        end
        S_DONE: begin
          // Spacer cycle: keeps START low long enough for the controller's
          // edge detector to see a fresh rising edge on the next command.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_arb.sv
// Scoreboard bench for flash_arb with a behavioural flash controller model.
// Latency: expected pulses carry the START-relative delay they must appear at.
// Backpressure: requesters hold REQ until GNT; controller model drives BUSY.
module tb_flash_arb;
  localparam int BW = 1;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [7:0]    req0_cmd, req1_cmd;
  logic [23:0]   req0_addr, req1_addr;
  logic [BW-1:0] req0_n, req1_n;
  logic [DW-1:0] req0_pd, req1_pd;
  logic          gnt0, gnt1, done0, done1, err0, err1;
  logic [DW-1:0] rd_data;
  logic [7:0]    fl_cmd;
  logic [23:0]   fl_addr;
  logic [BW-1:0] fl_n;
  logic [DW-1:0] fl_pdata_o;
  logic          fl_start;
  logic [DW-1:0] fl_pdata_i;
  logic          fl_busy, fl_finish;

  flash_arb #(.C_MAX_BYTE_NUM(1), .C_TIMEOUT_CLK_NUM(32'd100)) dut (
    .SYS_CLK_I(clk), .SYS_RST_I(rst),
    .REQ0_I(req0), .REQ0_CMD_I(req0_cmd), .REQ0_ADDR_I(req0_addr),
    .REQ0_BYTE_NUM_I(req0_n), .REQ0_PDATA_I(req0_pd),
    .REQ1_I(req1), .REQ1_CMD_I(req1_cmd), .REQ1_ADDR_I(req1_addr),
    .REQ1_BYTE_NUM_I(req1_n), .REQ1_PDATA_I(req1_pd),
    .GNT0_O(gnt0), .GNT1_O(gnt1), .DONE0_O(done0), .DONE1_O(done1),
    .ERR0_O(err0), .ERR1_O(err1), .RD_DATA_O(rd_data),
    .FL_CMD_O(fl_cmd), .FL_ADDR_O(fl_addr), .FL_BYTE_NUM_O(fl_n),
    .FL_PDATA_O(fl_pdata_o), .FL_START_O(fl_start),
    .FL_PDATA_I(fl_pdata_i), .FL_BUSY_I(fl_busy), .FL_FINISH_I(fl_finish)
  );

  always #5 clk = ~clk;

  // kind: 0 GNT, 1 DONE, 2 ERR. delta < 0 means "no timing check".
  typedef struct {
    int            kind;
    int            id;
    logic [7:0]    cmd;
    logic [23:0]   addr;
    logic [BW-1:0] n;
    logic [DW-1:0] dat;
    int            delta;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   to_cnt = 0;
  int   to_seen = 0;
  int   cyc = 0;
  int   last_start = 0;
  logic prev_start = 1'b0;
  logic rst_q = 1'b0;
  logic [DW-1:0] prev_rd = '0;

  // Controller model configuration (written by the stimulus only).
  int          ctl_delay = 2;
  logic        ctl_mute = 1'b0;
  logic [7:0]  ctl_data = 8'hA5;
  logic        pu_tgl = 1'b0;

  // ---------------- controller model ----------------
  // Read data returned is ctl_data ^ addr[7:0]; FINISH comes ctl_delay
  // cycles after the START cycle. A power-up read holds BUSY for 200 cycles
  // with a stray FINISH in the middle.
  initial begin
    int         m_cnt;
    logic       m_pu;
    logic       pu_seen;
    logic [7:0] m_data;
    m_cnt = 0; m_pu = 1'b0; pu_seen = 1'b0; m_data = '0;
    fl_busy = 1'b0; fl_finish = 1'b0; fl_pdata_i = '0;
    forever begin
      @(posedge clk); #1;
      fl_finish = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_pu && m_cnt == 100) begin
          fl_pdata_i = 8'h5A;
          fl_finish  = 1'b1;
        end
        if (m_cnt == 0) begin
          fl_busy = 1'b0;
          if (!m_pu) begin
            fl_pdata_i = m_data;
            fl_finish  = 1'b1;
          end
        end
      end else if (pu_tgl != pu_seen) begin
        pu_seen = pu_tgl; m_pu = 1'b1; m_cnt = 200; fl_busy = 1'b1;
      end else if (fl_start && !ctl_mute) begin
        m_pu = 1'b0; m_data = ctl_data ^ fl_addr[7:0]; m_cnt = ctl_delay; fl_busy = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) rst_q <= rst;

  task automatic check_ev(input int kind, input int id);
    exp_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d id=%0d at cycle %0d, expected none", kind, id, cyc);
      return;
    end
    e = q.pop_front();
    if (e.kind != kind || e.id != id) begin
      n_fail++;
      $display("FAIL event_order got kind=%0d id=%0d, expected kind=%0d id=%0d", kind, id, e.kind, e.id);
    end else if (kind == 0) begin
      if (!fl_start || fl_cmd != e.cmd || fl_addr != e.addr || fl_n != e.n || fl_pdata_o != e.dat) begin
        n_fail++;
        $display("FAIL grant%0d_fields got start=%0b cmd=%h addr=%h n=%h pd=%h, expected start=1 cmd=%h addr=%h n=%h pd=%h",
                 id, fl_start, fl_cmd, fl_addr, fl_n, fl_pdata_o, e.cmd, e.addr, e.n, e.dat);
      end
    end else begin
      if (rd_data != e.dat || (e.delta >= 0 && cyc - last_start != e.delta)) begin
        n_fail++;
        $display("FAIL %s%0d got rd_data=%h delay=%0d, expected rd_data=%h delay=%0d",
                 (kind == 1) ? "done" : "err", id, rd_data, cyc - last_start, e.dat, e.delta);
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (to_cnt != to_seen) begin
      n_chk++;
      n_fail++;
      to_seen = to_cnt;
    end
    if (rst_q) begin
      n_chk++;
      if ({gnt0, gnt1, done0, done1, err0, err1, fl_start} != 7'b0 ||
          rd_data != '0 || fl_cmd != '0 || fl_addr != '0 || fl_n != '0 || fl_pdata_o != '0) begin
        n_fail++;
        $display("FAIL reset_outputs got pulses=%b rd=%h cmd=%h addr=%h, expected all zero",
                 {gnt0, gnt1, done0, done1, err0, err1, fl_start}, rd_data, fl_cmd, fl_addr);
      end
    end
    if (fl_start) begin
      n_chk++;
      if (prev_start) begin
        n_fail++;
        $display("FAIL start_width got START high 2 cycles, expected 1");
      end
      last_start = cyc;
    end
    prev_start = fl_start;
    if (rd_data !== prev_rd) begin
      n_chk++;
      if (!(done0 || done1 || rst_q)) begin
        n_fail++;
        $display("FAIL rd_data_hold got %h without DONE, expected %h", rd_data, prev_rd);
      end
    end
    prev_rd = rd_data;
    if (gnt0)  check_ev(0, 0);
    if (gnt1)  check_ev(0, 1);
    if (done0) check_ev(1, 0);
    if (done1) check_ev(1, 1);
    if (err0)  check_ev(2, 0);
    if (err1)  check_ev(2, 1);
  end

  // ---------------- stimulus ----------------
  function automatic void push_g(input int id, input logic [7:0] cmd, input logic [23:0] addr,
                                 input logic [BW-1:0] n, input logic [DW-1:0] pd);
    exp_t e;
    e.kind = 0; e.id = id; e.cmd = cmd; e.addr = addr; e.n = n; e.dat = pd; e.delta = -1;
    q.push_back(e);
  endfunction

  function automatic void push_r(input int kind, input int id, input logic [DW-1:0] dat, input int delta);
    exp_t e;
    e.kind = kind; e.id = id; e.cmd = '0; e.addr = '0; e.n = '0; e.dat = dat; e.delta = delta;
    q.push_back(e);
  endfunction

  task automatic request(input int id, input logic [7:0] cmd, input logic [23:0] addr,
                         input logic [BW-1:0] n, input logic [DW-1:0] pd);
    int   k;
    logic g;
    if (id == 0) begin req0_cmd = cmd; req0_addr = addr; req0_n = n; req0_pd = pd; req0 = 1'b1; end
    else         begin req1_cmd = cmd; req1_addr = addr; req1_n = n; req1_pd = pd; req1 = 1'b1; end
    k = 0; g = 1'b0;
    while (!g && k < 1000) begin
      @(negedge clk);
      k++;
      g = (id == 0) ? gnt0 : gnt1;
    end
    if (!g) begin
      $display("FAIL grant%0d_wait got no GNT in 1000 cycles, expected GNT", id);
      to_cnt++;
    end
    // Scramble fields after the grant: the issued command must not change.
    if (id == 0) begin req0 = 1'b0; req0_addr = ~addr; req0_cmd = ~cmd; req0_pd = ~pd; end
    else         begin req1 = 1'b0; req1_addr = ~addr; req1_cmd = ~cmd; req1_pd = ~pd; end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) begin
      $display("FAIL drain got %0d pending responses, expected 0", q.size());
      to_cnt++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    req0 = 1'b0; req0_cmd = '0; req0_addr = '0; req0_n = '0; req0_pd = '0;
    req1 = 1'b0; req1_cmd = '0; req1_addr = '0; req1_n = '0; req1_pd = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic read by client 0: data A5, FINISH 3 cycles after START.
    ctl_delay = 3;
    push_g(0, 8'd1, 24'h000100, 1'b1, 8'h00);
    push_r(1, 0, 8'hA5, 4);
    request(0, 8'd1, 24'h000100, 1'b1, 8'h00);
    wait_drain();

    // Simultaneous requests with PRI=0 (fresh reset), two rounds.
    do_reset(1);
    repeat (2) @(negedge clk);
    ctl_delay = 2;
    for (int r = 0; r < 2; r++) begin
      push_g(0, 8'd0, 24'h000012, 1'b1, 8'hC3);
      push_r(1, 0, 8'hB7, 3);
      push_g(1, 8'd1, 24'h000034, 1'b1, 8'h00);
      push_r(1, 1, 8'h91, 3);
      fork
        request(0, 8'd0, 24'h000012, 1'b1, 8'hC3);
        request(1, 8'd1, 24'h000034, 1'b1, 8'h00);
      join
      wait_drain();
    end

    // Power-up read: no grant while BUSY, stray FINISH ignored.
    pu_tgl = ~pu_tgl;
    repeat (3) @(negedge clk);
    fork
      request(1, 8'd2, 24'h0ABCDE, 1'b1, 8'h00);
      begin
        k = 0;
        while (fl_busy && k < 400) begin
          @(negedge clk);
          k++;
        end
        push_g(1, 8'd2, 24'h0ABCDE, 1'b1, 8'h00);
        push_r(1, 1, 8'h7B, 3);
      end
    join
    wait_drain();

    // Watchdog: FINISH never comes; ERR0 100 cycles after START, data held.
    ctl_mute = 1'b1;
    push_g(0, 8'd3, 24'h000000, 1'b1, 8'h00);
    push_r(2, 0, 8'h7B, 100);
    request(0, 8'd3, 24'h000000, 1'b1, 8'h00);
    wait_drain();
    ctl_mute = 1'b0;

    // FINISH on the expiry cycle: DONE only.
    ctl_delay = 99;
    push_g(0, 8'd1, 24'h000055, 1'b1, 8'h00);
    push_r(1, 0, 8'hF0, 100);
    request(0, 8'd1, 24'h000055, 1'b1, 8'h00);
    wait_drain();

    // Reset during S_WAIT: command dropped, late FINISH ignored, PRI back to 0.
    ctl_delay = 20;
    push_g(1, 8'd1, 24'h000077, 1'b1, 8'h00);
    request(1, 8'd1, 24'h000077, 1'b1, 8'h00);
    repeat (3) @(negedge clk);
    do_reset(1);
    ctl_delay = 2;
    push_g(0, 8'd1, 24'h000001, 1'b1, 8'h00);
    push_r(1, 0, 8'hA4, 3);
    push_g(1, 8'd1, 24'h000002, 1'b1, 8'h00);
    push_r(1, 1, 8'hA7, 3);
    fork
      request(0, 8'd1, 24'h000001, 1'b1, 8'h00);
      request(1, 8'd1, 24'h000002, 1'b1, 8'h00);
    join
    wait_drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
